// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the GMII transmit state encoding.
package eth_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } tx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state function, shared by the TX MAC and RX checker.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    always_comb begin
        crc_next = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFL) : (crc_next >> 1);
        end
    end
endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: preamble/SFD, FIFO payload, zero pad, optional FCS and enforced IFG.
module gmii_tx_mac
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MIN_FRAME    = 60,
    parameter int APPEND_FCS   = 1,
    parameter int LEN_W        = 11,
    parameter int SYNC_STAGES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [LEN_W-1:0] len,
    input  logic             len_req,
    output logic             len_ack,
    output logic [7:0]       gmii_tx_data,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             busy,
    output logic             underflow
);
    localparam int PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int PAD_W = (MIN_FRAME > 1) ? $clog2(MIN_FRAME) : 1;
    localparam int IFG_W = (IFG_LEN > 1) ? $clog2(IFG_LEN) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [PAD_W-1:0] PAD_TOP = PAD_W'((MIN_FRAME > 0) ? MIN_FRAME - 1 : 0);
    localparam logic [IFG_W-1:0] IFG_TOP = IFG_W'(IFG_LEN - 1);
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_FRAME);
    localparam tx_state_t        TAIL    = (APPEND_FCS != 0) ? S_FCS : S_IFG;

    tx_state_t              state;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       remaining;
    logic [PRE_W-1:0]       pre_cnt;
    logic [PAD_W-1:0]       pad_cnt;
    logic [IFG_W-1:0]       ifg_cnt;
    logic [1:0]             fcs_cnt;
    logic                   uf_seen;
    logic [31:0]            crc;
    logic [31:0]            crc_next;
    logic [7:0]             crc_in;
    logic [7:0]             fcs_byte;
    logic                   pad_needed;

    assign req_s      = req_sync[SYNC_STAGES-1];
    assign busy       = (state != S_IDLE);
    assign fifo_rd    = !rst && (state == S_DATA) && !fifo_empty && (remaining != '0);
    assign crc_in     = (state == S_PAD) ? 8'h00 : fifo_data;
    assign pad_needed = (len_r < MIN_L);
    // fcs_cnt counts 3..0, so ~fcs_cnt selects bytes 0..3 of ~crc (LSB first).
    assign fcs_byte   = 8'((~crc) >> {~fcs_cnt, 3'b000});

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_in),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            req_sync     <= '0;
            len_ack      <= 1'b0;
            gmii_tx_data <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            underflow    <= 1'b0;
            uf_seen      <= 1'b0;
            remaining    <= '0;
            pre_cnt      <= '0;
            pad_cnt      <= '0;
            ifg_cnt      <= '0;
            fcs_cnt      <= '0;
        end else begin
            req_sync     <= {req_sync[SYNC_STAGES-2:0], len_req};
            gmii_tx_data <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            underflow    <= 1'b0;
            if (!req_s) len_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A zero-length request is acknowledged but never leaves IDLE.
                    if (req_s && !len_ack) begin
                        len_ack   <= 1'b1;
                        len_r     <= len;
                        remaining <= len;
                        uf_seen   <= 1'b0;
                        pre_cnt   <= PRE_TOP;
                        if (len != '0) state <= S_PRE;
                    end
                end
                S_PRE: begin
                    gmii_tx_en   <= 1'b1;
                    gmii_tx_data <= PREAMBLE_BYTE;
                    if (pre_cnt == '0) state <= S_SFD;
                    else pre_cnt <= pre_cnt - 1'b1;
                end
                S_SFD: begin
                    gmii_tx_en   <= 1'b1;
                    gmii_tx_data <= SFD_BYTE;
                    crc          <= CRC32_INIT;
                    pad_cnt      <= PAD_TOP - len_r[PAD_W-1:0];
                    fcs_cnt      <= 2'd3;
                    ifg_cnt      <= IFG_TOP;
                    state        <= S_DATA;
                end
                S_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (fifo_rd) begin
                        gmii_tx_data <= fifo_data;
                        crc          <= crc_next;
                        remaining    <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) state <= pad_needed ? S_PAD : TAIL;
                    end else begin
                        // Stall: byte count and CRC hold, the cycle is marked as an error.
                        gmii_tx_er <= 1'b1;
                        underflow  <= !uf_seen;
                        uf_seen    <= 1'b1;
                    end
                end
                S_PAD: begin
                    gmii_tx_en <= 1'b1;
                    crc        <= crc_next;
                    if (pad_cnt == '0) state <= TAIL;
                    else pad_cnt <= pad_cnt - 1'b1;
                end
                S_FCS: begin
                    gmii_tx_en   <= 1'b1;
                    gmii_tx_data <= fcs_byte;
                    if (fcs_cnt == 2'd0) state <= S_IFG;
                    else fcs_cnt <= fcs_cnt - 1'b1;
                end
                S_IFG: begin
                    if (ifg_cnt == '0) state <= S_IDLE;
                    else ifg_cnt <= ifg_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/gmii_tx_mac.md
# gmii_tx_mac

Parametrised GMII transmit MAC that turns a byte FIFO plus a per-frame length into a complete Ethernet frame on GMII. It emits the preamble and SFD, then the payload, then zero padding up to the minimum frame size, then an optional CRC-32 FCS, and finally an enforced inter-frame gap. It sits between the TX packet FIFO and the PHY. Frame length arrives from the producer domain over a synchronised 4-phase req/ack handshake. FIFO underflow is signalled on `gmii_tx_er`.

## Interface
- `PREAMBLE_LEN`, default 7: count of 0x55 bytes before the SFD; must be ≥1.
- `IFG_LEN`, default 12: idle cycles enforced after each frame; must be ≥1.
- `MIN_FRAME`, default 60: minimum payload-plus-pad bytes, FCS excluded; 0 disables padding.
- `APPEND_FCS`, default 1: 1 appends a 4-byte CRC-32; 0 omits it.
- `LEN_W`, default 11: width of the length field.
- `SYNC_STAGES`, default 3: synchroniser depth on `len_req`; must be ≥2.
- `clk`  in  1  GMII TX clock.
- `rst`  in  1  synchronous reset, active-high.
- `fifo_data`  in  8  show-ahead FIFO head; valid when `!fifo_empty`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd`  out  1  pop strobe; combinational.
- `len`  in  LEN_W  payload byte count; held stable while `len_req` is high.
- `len_req`  in  1  length request from the asynchronous producer domain.
- `len_ack`  out  1  length acknowledge.
- `gmii_tx_data`  out  8  GMII TXD.
- `gmii_tx_en`  out  1  GMII TX_EN.
- `gmii_tx_er`  out  1  GMII TX_ER.
- `busy`  out  1  high in any state other than IDLE.
- `underflow`  out  1  one-cycle pulse, at most once per frame.

## Operation
- **States:** IDLE → PRE → SFD → DATA → PAD → FCS → IFG → IDLE.
- **Handshake:**
  - `len_req` passes through SYNC_STAGES flops; call the output `req_s`.
  - In IDLE, when `req_s`=1 and `len_ack`=0: capture `len`, set `len_ack`=1.
  - `len_ack` clears on the first cycle `req_s`=0, in any state.
  - A new request is accepted only in IDLE with `len_ack`=0, so one req pulse never starts two frames.
- **len=0:** acknowledged and dropped. No GMII activity; stays in IDLE.
- **PRE:** PREAMBLE_LEN cycles of 0x55 with `tx_en`=1.
- **SFD:** one cycle of 0xD5. The CRC register is initialised to 0xFFFFFFFF.
- **DATA:**
  - `fifo_rd` = (state==DATA) && `!fifo_empty` && remaining>0.
  - The popped byte appears on `gmii_tx_data` the next cycle and is fed to the CRC.
  - Underflow (DATA, remaining>0, `fifo_empty`=1): next cycle drives `tx_en`=1, `tx_er`=1, data 0x00. The remaining count does not decrement and the CRC is not updated. The frame finishes with its full byte count.
  - `underflow` pulses on the first such cycle of a frame only.
- **PAD:** max(0, MIN_FRAME−len) bytes of 0x00, included in the CRC. Skipped when len ≥ MIN_FRAME.
- **FCS:** when APPEND_FCS=1, 4 bytes of ~CRC, least-significant byte first. Otherwise PAD goes straight to IFG.
- **IFG:** IFG_LEN cycles with `tx_en`=0 and data 0x00, then IDLE.
- **CRC:** reflected CRC-32, polynomial 0x04C11DB7 (reflected form 0xEDB88320), 8 bits per cycle.
- **Counters:**
  - The remaining-byte counter is LEN_W bits.
  - The pad and IFG counters are sized by $clog2 of their parameter.
  - No counter wraps: each state exits when its counter hits 0.

## Timing
- **Reset values:** every output is 0 (`fifo_rd`, `len_ack`, `gmii_tx_data`, `gmii_tx_en`, `gmii_tx_er`, `busy`, `underflow`). State = IDLE, synchroniser cleared.
- **Reset mid-frame:** outputs return to 0 on the next edge. The frame is truncated with no `tx_er` marking.
- **Registered outputs:** all GMII outputs are registered. Only `fifo_rd` is combinational.
- **Latency:** `len_req` edge → `len_ack`=1 takes SYNC_STAGES+1 cycles. `gmii_tx_en` rises the cycle after capture.
- **Frame duration:** `tx_en` stays high for PREAMBLE_LEN + 1 + max(len, MIN_FRAME) + 4·APPEND_FCS cycles, plus one cycle per underflow stall.
- **Gap:** minimum capture-to-capture spacing is frame duration + IFG_LEN + 1 cycles.

## Structure
- Package `eth_pkg` holds:
  - PREAMBLE_BYTE 0x55 and SFD_BYTE 0xD5;
  - CRC32_POLY_REFL 0xEDB88320, CRC32_INIT 0xFFFFFFFF and CRC32_RESIDUE 0xDEBB20E3;
  - the `tx_state_t` enum.
- Sub-module `crc32_d8`: combinational next-CRC function taking crc[31:0] and data[7:0]. It is shared with the future RX checker.

## Test plan
- **Basic frame:** len=64, FIFO holds 0x00..0x3F → 7×0x55, 0xD5, 64 data bytes, 4 FCS bytes, then exactly 12 cycles of `tx_en`=0. The captured frame through FCS leaves CRC residue 0xDEBB20E3.
- **Known FCS:** MIN_FRAME=0, len=9, payload "123456789" → FCS bytes 0x26 0x39 0xF4 0xCB.
- **Padding:** len=10 → 10 data bytes, then 50×0x00, then FCS; `tx_en` high for 7+1+60+4=72 cycles.
- **Underflow:** `fifo_empty` forced high for 3 cycles mid-DATA → 3 cycles with `tx_er`=1 and data 0x00, a single `underflow` pulse, all len bytes still sent, frame 3 cycles longer.
- **Held request / back-to-back:**
  - `len_req` held high across a whole frame → exactly one frame, with `len_ack` high until the synchronised req falls.
  - A second request raised during the frame → captured no earlier than IFG end + 1.
  - A len=0 request → `len_ack` toggles, no `tx_en` activity.
- **Reset mid-PAD:** assert `rst` → the next cycle has all outputs 0 and `busy`=0. The following request produces a correct frame.
